// File: rtl/vec_csr_regs.sv
// Vector configuration CSRs (vtype/vl/vlmax/vstart) driven by vset{i}vl{i} execute pulses,
// with a handshaked scalar writeback of the new vl.
module vec_csr_regs #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_wr_en,
  input  logic [XLEN-1:0] vtype_i,
  input  logic [XLEN-1:0] avl_i,
  input  logic            avl_max_i,
  input  logic            keep_vl_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            vstart_wr_en,
  input  logic [XLEN-1:0] vstart_i,
  output logic [XLEN-1:0] csr_vtype_o,
  output logic [XLEN-1:0] csr_vl_o,
  output logic [XLEN-1:0] csr_vlmax_o,
  output logic [XLEN-1:0] csr_vstart_o,
  output logic            vill_o,
  output logic            busy_o,
  output logic            rd_wr_valid_o,
  input  logic            rd_wr_ready_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_wdata_o
);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_e;

  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] VLEN_X     = XLEN'(VLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] vtype_cap_q, vtype_cap_d;
  logic [XLEN-1:0] avl_cap_q, avl_cap_d;
  logic            avl_max_q, avl_max_d;
  logic            keep_vl_q, keep_vl_d;
  logic [4:0]      rd_cap_q, rd_cap_d;
  logic [XLEN-1:0] vtype_q, vtype_d;
  logic [XLEN-1:0] vl_q, vl_d;
  logic [XLEN-1:0] vlmax_q, vlmax_d;
  logic [XLEN-1:0] vstart_q, vstart_d;

  logic [2:0]      vlmul, vsew;
  logic [XLEN-1:0] elems_per_reg, vlmax_calc;
  logic            illegal;

  // VLEN/SEW as a shift; fractional LMUL shifts right by 8-vlmul
  always_comb begin
    vlmul         = vtype_cap_q[2:0];
    vsew          = vtype_cap_q[5:3];
    elems_per_reg = VLEN_X >> (3'd3 + {1'b0, vsew[1:0]});
    if (vlmul[2]) vlmax_calc = elems_per_reg >> (4'd8 - {1'b0, vlmul});
    else          vlmax_calc = elems_per_reg << vlmul[1:0];
    illegal = vsew[2] | (vlmul == 3'b100) | (|vtype_cap_q[XLEN-1:8]) | (vlmax_calc == '0);
  end

  always_comb begin
    state_d     = state_q;
    vtype_cap_d = vtype_cap_q;
    avl_cap_d   = avl_cap_q;
    avl_max_d   = avl_max_q;
    keep_vl_d   = keep_vl_q;
    rd_cap_d    = rd_cap_q;
    vtype_d     = vtype_q;
    vl_d        = vl_q;
    vlmax_d     = vlmax_q;
    vstart_d    = vstart_q;
    case (state_q)
      IDLE: begin
        if (csr_wr_en) begin
          vtype_cap_d = vtype_i;
          avl_cap_d   = avl_i;
          avl_max_d   = avl_max_i;
          keep_vl_d   = keep_vl_i;
          rd_cap_d    = rd_addr_i;
          state_d     = CALC;
        end else if (vstart_wr_en) begin
          vstart_d = vstart_i;
        end
      end
      CALC: begin
        vstart_d = '0;
        if (illegal) begin
          vtype_d = VILL_VTYPE;
          vl_d    = '0;
          vlmax_d = '0;
        end else begin
          vtype_d = vtype_cap_q;
          vlmax_d = vlmax_calc;
          // keep_vl takes priority over avl_max when both are set
          if (keep_vl_q)      vl_d = (vl_q < vlmax_calc) ? vl_q : vlmax_calc;
          else if (avl_max_q) vl_d = vlmax_calc;
          else                vl_d = (avl_cap_q < vlmax_calc) ? avl_cap_q : vlmax_calc;
        end
        state_d = (rd_cap_q != 5'd0) ? WB : IDLE;
      end
      WB: begin
        if (rd_wr_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vtype_cap_q <= '0;
      avl_cap_q   <= '0;
      avl_max_q   <= 1'b0;
      keep_vl_q   <= 1'b0;
      rd_cap_q    <= '0;
      vtype_q     <= VILL_VTYPE;
      vl_q        <= '0;
      vlmax_q     <= '0;
      vstart_q    <= '0;
    end else begin
      state_q     <= state_d;
      vtype_cap_q <= vtype_cap_d;
      avl_cap_q   <= avl_cap_d;
      avl_max_q   <= avl_max_d;
      keep_vl_q   <= keep_vl_d;
      rd_cap_q    <= rd_cap_d;
      vtype_q     <= vtype_d;
      vl_q        <= vl_d;
      vlmax_q     <= vlmax_d;
      vstart_q    <= vstart_d;
    end
  end

  assign csr_vtype_o   = vtype_q;
  assign csr_vl_o      = vl_q;
  assign csr_vlmax_o   = vlmax_q;
  assign csr_vstart_o  = vstart_q;
  assign vill_o        = vtype_q[XLEN-1];
  assign busy_o        = (state_q != IDLE);
  assign rd_wr_valid_o = (state_q == WB);
  assign rd_addr_o     = (state_q == WB) ? rd_cap_q : '0;
  assign rd_wdata_o    = (state_q == WB) ? vl_q : '0;

endmodule

// File: tb/tb_vec_csr_regs.sv
// Directed + randomized bench for vec_csr_regs against an arithmetic model of the vset rules.
module tb_vec_csr_regs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned VLEN = 512;

  logic            clk = 1'b0;
  logic            reset, csr_wr_en, avl_max_i, keep_vl_i, vstart_wr_en, rd_wr_ready_i;
  logic [XLEN-1:0] vtype_i, avl_i, vstart_i;
  logic [4:0]      rd_addr_i, rd_addr_o;
  logic [XLEN-1:0] csr_vtype_o, csr_vl_o, csr_vlmax_o, csr_vstart_o, rd_wdata_o;
  logic            vill_o, busy_o, rd_wr_valid_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_vtype, m_vl, m_vlmax, m_vstart;

  vec_csr_regs #(.XLEN(XLEN), .VLEN(VLEN)) dut (
    .clk(clk), .reset(reset), .csr_wr_en(csr_wr_en), .vtype_i(vtype_i), .avl_i(avl_i),
    .avl_max_i(avl_max_i), .keep_vl_i(keep_vl_i), .rd_addr_i(rd_addr_i),
    .vstart_wr_en(vstart_wr_en), .vstart_i(vstart_i), .csr_vtype_o(csr_vtype_o),
    .csr_vl_o(csr_vl_o), .csr_vlmax_o(csr_vlmax_o), .csr_vstart_o(csr_vstart_o),
    .vill_o(vill_o), .busy_o(busy_o), .rd_wr_valid_o(rd_wr_valid_o),
    .rd_wr_ready_i(rd_wr_ready_i), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one config instruction, from SEW/LMUL arithmetic.
  task automatic model_cfg(input logic [31:0] vt, input logic [31:0] avl, input bit amax, input bit keep);
    longint unsigned sew, vlmax;
    bit ill;
    sew   = 64'd8 << vt[5:3];
    ill   = (vt[5:3] > 3) || (vt[2:0] == 3'b100) || (vt[31:8] != 0);
    vlmax = 0;
    if (!ill) begin
      case (vt[2:0])
        3'd0: vlmax = VLEN / sew;
        3'd1: vlmax = VLEN * 2 / sew;
        3'd2: vlmax = VLEN * 4 / sew;
        3'd3: vlmax = VLEN * 8 / sew;
        3'd5: vlmax = VLEN / (sew * 8);
        3'd6: vlmax = VLEN / (sew * 4);
        default: vlmax = VLEN / (sew * 2);
      endcase
      if (vlmax == 0) ill = 1;
    end
    m_vstart = 0;
    if (ill) begin
      m_vtype = 32'h8000_0000; m_vl = 0; m_vlmax = 0;
    end else begin
      m_vtype = vt; m_vlmax = 32'(vlmax);
      if (keep)      m_vl = (m_vl < m_vlmax) ? m_vl : m_vlmax;
      else if (amax) m_vl = m_vlmax;
      else           m_vl = (avl < m_vlmax) ? avl : m_vlmax;
    end
  endtask

  task automatic chk_csrs(input string tag);
    chk({tag, "_vtype"},  csr_vtype_o,  m_vtype);
    chk({tag, "_vl"},     csr_vl_o,     m_vl);
    chk({tag, "_vlmax"},  csr_vlmax_o,  m_vlmax);
    chk({tag, "_vstart"}, csr_vstart_o, m_vstart);
    chk({tag, "_vill"},   32'(vill_o),  32'(m_vtype[31]));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy_o),        0);
    chk({tag, "_valid"}, 32'(rd_wr_valid_o), 0);
    chk({tag, "_addr"},  32'(rd_addr_o),     0);
    chk({tag, "_wdata"}, rd_wdata_o,         0);
  endtask

  // Full config transaction; dly = WB cycles with ready low (one late csr_wr_en poked in).
  task automatic cfg(input logic [31:0] vt, input logic [31:0] avl, input bit amax, input bit keep,
                     input logic [4:0] rd, input int unsigned dly, input bit vs_too);
    csr_wr_en = 1; vtype_i = vt; avl_i = avl; avl_max_i = amax; keep_vl_i = keep; rd_addr_i = rd;
    vstart_wr_en = vs_too; vstart_i = 32'h55;
    tick();
    csr_wr_en = 0; vstart_wr_en = 0;
    vtype_i = $urandom; avl_i = $urandom; rd_addr_i = 5'($urandom);
    avl_max_i = 1'($urandom); keep_vl_i = 1'($urandom);
    chk("calc_busy", 32'(busy_o), 1);
    chk("calc_valid", 32'(rd_wr_valid_o), 0);
    chk("calc_vl_old", csr_vl_o, m_vl);
    model_cfg(vt, avl, amax, keep);
    tick();
    chk_csrs("upd");
    if (rd != 0) begin
      chk("wb_valid", 32'(rd_wr_valid_o), 1);
      chk("wb_addr", 32'(rd_addr_o), 32'(rd));
      chk("wb_wdata", rd_wdata_o, m_vl);
      for (int unsigned k = 0; k < dly; k++) begin
        if (k == 0) begin csr_wr_en = 1; vtype_i = 32'h3; avl_i = 32'd1; end
        tick();
        csr_wr_en = 0;
        chk("stall_valid", 32'(rd_wr_valid_o), 1);
        chk("stall_busy", 32'(busy_o), 1);
        chk("stall_addr", 32'(rd_addr_o), 32'(rd));
        chk("stall_wdata", rd_wdata_o, m_vl);
      end
      rd_wr_ready_i = 1;
      tick();
      rd_wr_ready_i = 0;
    end
    chk_idle("idle");
    chk_csrs("post");
  endtask

  task automatic wr_vstart(input logic [31:0] v);
    vstart_wr_en = 1; vstart_i = v;
    tick();
    vstart_wr_en = 0;
    m_vstart = v;
    chk("vstart_wr", csr_vstart_o, m_vstart);
  endtask

  initial begin
    reset = 1; csr_wr_en = 0; avl_max_i = 0; keep_vl_i = 0; vstart_wr_en = 0;
    rd_wr_ready_i = 0; vtype_i = 0; avl_i = 0; vstart_i = 0; rd_addr_i = 0;
    m_vtype = 32'h8000_0000; m_vl = 0; m_vlmax = 0; m_vstart = 0;
    tick(); tick();
    chk_csrs("rst");
    chk_idle("rst");
    reset = 0;
    tick();

    cfg(32'h10, 32'd20, 0, 0, 5'd5, 0, 0);
    chk("sew32_vl", csr_vl_o, 32'd16);
    cfg(32'h03, 32'd0, 1, 0, 5'd1, 1, 0);
    chk("lmul8_vl", csr_vl_o, 32'd512);
    cfg(32'h1D, 32'd0, 0, 1, 5'd0, 0, 0);
    chk("frac_vl", csr_vl_o, 32'd1);
    cfg(32'h20, 32'd9, 0, 0, 5'd3, 0, 0);
    chk("vsew4_vill", 32'(vill_o), 1);
    cfg(32'h100, 32'd9, 0, 0, 5'd3, 0, 0);
    chk("resv_vtype", csr_vtype_o, 32'h8000_0000);
    cfg(32'h10, 32'd7, 0, 0, 5'd9, 3, 0);
    wr_vstart(32'd7);
    cfg(32'h10, 32'd300, 0, 0, 5'd2, 0, 1);
    chk("vstart_cleared", csr_vstart_o, 0);
    cfg(32'hD0, 32'hFFFF_FFFF, 0, 0, 5'd4, 0, 0);

    // Reset while a writeback is pending.
    csr_wr_en = 1; vtype_i = 32'h10; avl_i = 32'd4; avl_max_i = 0; keep_vl_i = 0; rd_addr_i = 5'd6;
    tick();
    csr_wr_en = 0;
    tick();
    chk("pre_rst_valid", 32'(rd_wr_valid_o), 1);
    reset = 1;
    tick();
    reset = 0;
    m_vtype = 32'h8000_0000; m_vl = 0; m_vlmax = 0; m_vstart = 0;
    chk_csrs("wbrst");
    chk_idle("wbrst");
    rd_wr_ready_i = 1;
    tick();
    rd_wr_ready_i = 0;
    chk_idle("no_replay");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] vt, avl;
      logic [4:0] rd;
      if ($urandom_range(0, 7) == 0) vt = $urandom;
      else if ($urandom_range(0, 5) == 0) vt = 32'($urandom_range(0, 255)) | 32'h100;
      else vt = 32'($urandom_range(0, 255));
      avl = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 600));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom_range(0, 4) == 0) wr_vstart($urandom);
      cfg(vt, avl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rd,
          $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_csr_regs.md
VEC_CSR_REGS -- requirements
Module: vec_csr_regs

Interface
REQ-001 SHALL have parameter XLEN, default 32, scalar/CSR data width.
REQ-002 SHALL have parameter VLEN, default 512, vector register length in bits (power of 2, 64..4096).
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- csr_wr_en  in  1  config-instruction execute pulse (vsetvli/vsetivli/vsetvl).
- vtype_i  in  XLEN  requested vtype, from the decode stage.
- avl_i  in  XLEN  requested AVL, from the decode stage.
- avl_max_i  in  1  rs1==x0, rd!=x0: vl = VLMAX.
- keep_vl_i  in  1  rs1==x0, rd==x0: keep current vl.
- rd_addr_i  in  5  scalar destination register.
- vstart_wr_en  in  1  vstart write strobe.
- vstart_i  in  XLEN  vstart write data.
- csr_vtype_o  out  XLEN  architectural vtype.
- csr_vl_o  out  XLEN  architectural vl.
- csr_vlmax_o  out  XLEN  VLMAX of current vtype.
- csr_vstart_o  out  XLEN  architectural vstart.
- vill_o  out  1  equals csr_vtype_o[XLEN-1].
- busy_o  out  1  high whenever state != IDLE.
- rd_wr_valid_o  out  1  scalar writeback valid.
- rd_wr_ready_i  in  1  scalar writeback ready.
- rd_addr_o  out  5  writeback register.
- rd_wdata_o  out  XLEN  writeback data (new vl).

Function
REQ-004 SHALL implement FSM IDLE, CALC, WB.
REQ-005 IDLE: csr_wr_en=1 SHALL capture vtype_i, avl_i, avl_max_i, keep_vl_i, rd_addr_i and go to CALC; csr_wr_en outside IDLE SHALL be ignored.
REQ-006 vtype fields: vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7]; bits [XLEN-2:8] reserved.
REQ-007 SEW=8<<vsew; LMUL codes 000/001/010/011 = 1/2/4/8, 101/110/111 = 1/8, 1/4, 1/2.
REQ-008 VLMAX: (VLEN/SEW)<<vlmul for integer LMUL; (VLEN/SEW)>>(8-vlmul) for fractional LMUL.
REQ-009 Illegal (vill) SHALL be: vsew>3, vlmul==100, any reserved bit or bit XLEN-1 set, or computed VLMAX==0.
REQ-010 CALC, legal: vtype=captured value; vlmax=VLMAX; vl = VLMAX if avl_max, else min(old vl, VLMAX) if keep_vl (keep_vl wins if both set), else min(avl, VLMAX), unsigned compare over full XLEN.
REQ-011 CALC, illegal: vtype = 1<<(XLEN-1); vl=0; vlmax=0.
REQ-012 CALC SHALL clear vstart to 0 and update all CSRs at the end of the single CALC cycle; new values are visible the cycle after CALC.
REQ-013 CALC SHALL go to WB if rd_addr != 0, else to IDLE.
REQ-014 WB: rd_wr_valid_o=1, rd_addr_o=captured rd, rd_wdata_o=new vl; stay in WB until rd_wr_ready_i=1, then go to IDLE the next cycle.
REQ-015 rd_addr_o and rd_wdata_o SHALL hold stable while rd_wr_valid_o=1 and ready=0.
REQ-016 Latency: csr_wr_en at cycle N gives CALC at N+1, CSRs updated at N+2, and rd_wr_valid_o=1 from N+2.
REQ-017 vstart_wr_en SHALL be honoured only in IDLE with csr_wr_en=0; if both are high in IDLE, the config write wins and vstart ends 0.
REQ-018 rd_wr_valid_o, rd_addr_o and rd_wdata_o SHALL be 0 outside WB.

Reset
REQ-019 On reset=1 at a clock edge: state=IDLE, csr_vtype_o=1<<(XLEN-1), vill_o=1, csr_vl_o=0, csr_vlmax_o=0, csr_vstart_o=0, rd_wr_valid_o=0, busy_o=0.
REQ-020 Reset in CALC or WB SHALL abort the operation; a pending writeback is dropped, not replayed.

Verification (VLEN=512, XLEN=32)
REQ-021 vtype=0x10 (SEW32, LMUL1), avl=20, rd=5 -> vlmax=16, vl=16; rd_wr_valid at N+2 with rd_wdata=16, rd_addr=5.
REQ-022 vtype=0x03 (SEW8, LMUL8), avl_max=1 -> vl=512; then vtype=0x1D (SEW64, LMUL1/8), keep_vl=1, rd=0 -> vlmax=1, vl=1, no writeback.
REQ-023 vtype=0x20 (vsew=4) or vtype=0x100 -> vtype=0x80000000, vill=1, vl=0, rd_wdata=0.
REQ-024 ready held 0 for 3 cycles in WB -> valid and data stable, busy=1, second csr_wr_en ignored; ready=1 -> IDLE the following cycle.
REQ-025 vstart_wr_en with vstart_i=7 in IDLE -> vstart=7; then csr_wr_en and vstart_wr_en together -> vstart=0.
REQ-026 reset asserted in WB -> next cycle valid=0, vill=1, vl=0, state IDLE.
